// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction RAM read port, branch redirect and decoder handshake.
// Width parameters must match the fetch_queue instance that uses the master modport.

interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic [DATA_W-1:0] imem_rdata;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    // dec_valid/dec_ready: the head entry transfers on a rising edge where both are 1;
    // dec_valid never waits for dec_ready, and dec_* are only meaningful while dec_valid=1.
    logic              dec_valid;
    logic              dec_ready;
    logic [DATA_W-1:0] dec_instr;
    logic [ADDR_W-1:0] dec_pc;
    logic [ADDR_W-1:0] dec_link;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output imem_addr, imem_req,
        input  imem_rdata,
        input  br_taken, br_target,
        output dec_valid,
        input  dec_ready,
        output dec_instr, dec_pc, dec_link, occupancy
    );

    modport slave (
        input  imem_addr, imem_req,
        output imem_rdata,
        output br_taken, br_target,
        input  dec_valid,
        output dec_ready,
        input  dec_instr, dec_pc, dec_link, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, reads a 1-cycle instruction RAM, queues words for decode.
// Optional FETCH_BYPASS_EN: a word returning into an empty queue is presented to the decoder immediately.

module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEM_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              dec_live;

    logic [DATA_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [DEM_W-1:0]  demand;
    logic              issue;
    logic              ret_valid;
    logic              bypass;
    logic              pop;
    logic              fifo_push;
    logic              fifo_pop;
    logic [1:0]        unused_tgt_lsb;

    assign unused_tgt_lsb = bus.br_target[1:0];

    always_comb begin
        // Words already queued plus the one still coming back must fit in the FIFO.
        demand    = DEM_W'(count) + DEM_W'(inflight);
        issue     = !reset && !bus.br_taken && (demand < DEM_W'(DEPTH));
        ret_valid = inflight && !reset && !bus.br_taken;
`ifdef FETCH_BYPASS_EN
        bypass    = ret_valid && (count == '0);
`else
        bypass    = 1'b0;
`endif
        pop       = bus.dec_valid && bus.dec_ready;
        fifo_pop  = pop && !bypass;
        fifo_push = ret_valid && !(bypass && bus.dec_ready);
    end

    always_comb begin
        bus.imem_addr = pc;
        bus.imem_req  = issue;
        bus.occupancy = count;
        bus.dec_valid = !reset && ((count != '0) || bypass);
        bus.dec_instr = bypass ? bus.imem_rdata : fifo_instr[rd_ptr];
        bus.dec_pc    = bypass ? inflight_pc    : fifo_pc[rd_ptr];
        // Link reads as zero until the first word has ever been presented after reset.
        bus.dec_link  = (dec_live || bypass) ? bus.dec_pc + ADDR_W'(4) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            dec_live    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (ret_valid) begin
                dec_live <= 1'b1;
            end
            if (bus.br_taken) begin
                // Redirect: drop queued words and the returning word; target issues next cycle.
                pc     <= {bus.br_target[ADDR_W-1:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (issue) begin
                    pc <= pc + ADDR_W'(4);
                end
                if (fifo_push) begin
                    fifo_instr[wr_ptr] <= bus.imem_rdata;
                    fifo_pc[wr_ptr]    <= inflight_pc;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                end
                if (fifo_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
                assert (!(fifo_push && !fifo_pop && count == CNT_W'(DEPTH)));
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed fetch/stall/redirect/wrap/reset scenarios, then random traffic.
// Expected decode stream: contiguous word addresses starting at the most recent reset or redirect.

module tb_fetch_queue;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0100;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] fill_pc;

  function automatic logic [DATA_W-1:0] imem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // scoreboard fill: expected pcs the decoder must see, in order
  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(fill_pc);
      fill_pc = fill_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [ADDR_W-1:0] start);
    exp_q.delete();
    fill_pc = start;
    top_up();
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic set_in(input logic rst, input logic rdy, input logic br, input logic [ADDR_W-1:0] tgt);
    reset         = rst;
    bus.dec_ready = rdy;
    bus.br_taken  = br;
    bus.br_target = tgt;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (reset) restart(RESET_PC);
    else if (bus.br_taken) restart(bus.br_target & ~32'h3);
    else top_up();
    #1;
  endtask

  task automatic cycle(input logic rst, input logic rdy, input logic br, input logic [ADDR_W-1:0] tgt);
    set_in(rst, rdy, br, tgt);
    finish_cycle();
  endtask

  // instruction RAM model: answers the previous cycle's request
  logic              rsp_req = 1'b0;
  logic [ADDR_W-1:0] rsp_addr = '0;
  always @(negedge clk) begin
    rsp_req  = bus.imem_req;
    rsp_addr = bus.imem_addr;
  end
  always @(posedge clk) begin
    #1;
    bus.imem_rdata = rsp_req ? imem_word(rsp_addr) : $urandom;
  end

  // monitor: every accepted head entry is checked against the expected stream
  always @(negedge clk) begin
    logic [ADDR_W-1:0] e;
    if (!reset) chk("occupancy_bound", 32'(bus.occupancy <= DEPTH), 32'd1);
    if (bus.dec_valid && bus.dec_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected at %0t: got pc %h, expected no entry", $time, bus.dec_pc);
      end else begin
        e = exp_q.pop_front();
        chk("dec_pc", bus.dec_pc, e);
        chk("dec_instr", bus.dec_instr, imem_word(e));
        chk("dec_link", bus.dec_link, e + 32'd4);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d n_err=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss;
    int w;
    logic got;
    bus.imem_rdata = '0;
    set_in(1'b1, 1'b0, 1'b0, '0);

    // reset values and first sequential fetches
    set_in(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("reset_imem_req", 32'(bus.imem_req), 32'd0);
    chk("reset_dec_valid", 32'(bus.dec_valid), 32'd0);
    finish_cycle();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (k == 0) begin
        chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
        chk("reset_dec_instr", bus.dec_instr, 32'd0);
        chk("reset_dec_pc", bus.dec_pc, 32'd0);
        chk("reset_dec_link", bus.dec_link, 32'd0);
      end
      if (k < 3) begin
        chk("seq_imem_addr", bus.imem_addr, RESET_PC + 32'(4 * k));
        chk("seq_imem_req", 32'(bus.imem_req), 32'd1);
      end
      if (k <= LAT) chk("first_valid_latency", 32'(bus.dec_valid), 32'(k == LAT));
      if (k == LAT) begin
        chk("first_dec_pc", bus.dec_pc, RESET_PC);
        chk("first_dec_link", bus.dec_link, RESET_PC + 32'd4);
      end
      finish_cycle();
    end

    // decoder stalled: exactly DEPTH reads, then the request line stays low
    cycle(1'b1, 1'b0, 1'b0, '0);
    n_iss = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      if (bus.imem_req) n_iss++;
      finish_cycle();
    end
    chk("stall_issue_count", 32'(n_iss), 32'(DEPTH));
    set_in(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    chk("stall_occupancy", 32'(bus.occupancy), 32'(DEPTH));
    chk("stall_no_req", 32'(bus.imem_req), 32'd0);
    finish_cycle();

    // full FIFO drained with ready held: a word leaves every cycle
    for (int k = 0; k < 12; k++) begin
      set_in(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("full_stream_valid", 32'(bus.dec_valid), 32'd1);
      finish_cycle();
    end

    // redirect with three words queued and one returning
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (w = 0; w < 20 && bus.occupancy != 3; w++) cycle(1'b0, 1'b0, 1'b0, '0);
    chk("reach_occupancy_3", 32'(bus.occupancy), 32'd3);
    set_in(1'b0, 1'b0, 1'b1, 32'h0000_0203);
    @(negedge clk);
    chk("br_cycle_no_req", 32'(bus.imem_req), 32'd0);
    finish_cycle();
    set_in(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("br_flush_occupancy", 32'(bus.occupancy), 32'd0);
    chk("br_target_addr", bus.imem_addr, 32'h0000_0200);
    chk("br_target_req", 32'(bus.imem_req), 32'd1);
    finish_cycle();
    got = 1'b0;
    for (w = 0; w < 10 && !got; w++) begin
      set_in(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (bus.dec_valid) begin
        chk("br_first_dec_pc", bus.dec_pc, 32'h0000_0200);
        got = 1'b1;
      end
      finish_cycle();
    end
    chk("br_first_word_seen", 32'(got), 32'd1);

    // PC wraps past the top of the address space
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("wrap_imem_addr", bus.imem_addr, 32'hFFFF_FFF8 + 32'(4 * k));
      finish_cycle();
    end

    // reset mid-stream with two words queued and a read in flight
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (w = 0; w < 20 && bus.occupancy != 2; w++) cycle(1'b0, 1'b0, 1'b0, '0);
    chk("reach_occupancy_2", 32'(bus.occupancy), 32'd2);
    cycle(1'b1, 1'b0, 1'b0, '0);
    set_in(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("midreset_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("midreset_occupancy", 32'(bus.occupancy), 32'd0);
    chk("midreset_imem_addr", bus.imem_addr, RESET_PC);
    finish_cycle();

    // random traffic: ready, redirects (some near the wrap point) and rare resets
    for (int k = 0; k < 3000; k++) begin
      logic rst, rdy, br;
      logic [ADDR_W-1:0] tgt;
      rst = ($urandom_range(0, 199) == 0);
      br  = ($urandom_range(0, 29) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      rdy = ($urandom_range(0, 9) < 7);
      cycle(rst, rdy, br, tgt);
    end
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 1'b0, '0);
    chk("random_progress", 32'(n_pop > 800), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
